// File: rtl/dmem_block_mover.sv
// Block COPY/FILL initiator for the DataMemory port, with a start/busy/done handshake.
// Define DMEM_MOVER_CHECKSUM_EN to enable the running sum of written bytes on `checksum`.
module dmem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic              MODE_FILL = 1'b1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [7:0]        remaining;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode only registered state, so start never reaches the memory port combinationally.
    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_wen        = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == 8'd0) begin
                        state_next = DONE;
                    end else if (mode == MODE_FILL) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_ptr;
                state_next  = WRITE;
            end
            WRITE: begin
                busy           = 1'b1;
                mem_wen        = 1'b1;
                mem_address    = dst_ptr;
                mem_write_data = (mode_q == MODE_FILL) ? fill_q : data_buf;
                if (remaining == 8'd1) begin
                    state_next = DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_next = WRITE;
                end else begin
                    state_next = READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            mode_q    <= 1'b0;
            fill_q    <= '0;
            data_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        mode_q    <= mode;
                        fill_q    <= fill_value;
                    end
                end
                READ: begin
                    data_buf <= mem_read_data;
                end
                WRITE: begin
                    // Pointers wrap naturally at 2**ADDR_W; overlapping copies stay strictly forward.
                    src_ptr   <= src_ptr + PTR_ONE;
                    dst_ptr   <= dst_ptr + PTR_ONE;
                    remaining <= remaining - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_MOVER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (state == IDLE && start) begin
            checksum_q <= '0;
        end else if (state == WRITE) begin
            checksum_q <= checksum_q + mem_write_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_block_mover.sv
// Scoreboard bench for dmem_block_mover: commands push expected completions, a done monitor checks them.
module tb_dmem_block_mover;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic       mem_wen;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    logic [7:0] mem [256];
    logic       mem_clear;
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur_acc  = 0;
    logic [31:0] wen_mask = '0;

    typedef struct {
        string             name;
        int                latency;
        logic [31:0]       wen_mask;
        logic [7:0]        csum;
        int                n_mem;
        logic [7:0][7:0]   addr;
        logic [7:0][7:0]   data;
    } exp_t;

    exp_t sb[$];

    dmem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_value     (fill_value),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum),
        .mem_wen        (mem_wen),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory model: combinational read, write on posedge; preload and clear ports for the bench.
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (mem_clear) begin
            foreach (mem[i]) mem[i] <= 8'h00;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_wen) begin
            mem[mem_address] <= mem_write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one command at a negedge, then scramble the operands right after the accept edge.
    task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] len, input logic [7:0] fv);
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        length     = len;
        fill_value = fv;
        cur_acc    = cyc;
        wen_mask   = '0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        mode       = ~m;
        src_addr   = 8'h99;
        dst_addr   = 8'h77;
        length     = 8'd9;
        fill_value = 8'h5A;
        @(negedge clk);
    endtask

    // Monitor: records write cycles relative to accept, and checks each done against the scoreboard.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (mem_wen) begin
            k = cyc - cur_acc;
            if (k >= 0 && k < 32) wen_mask[k] = 1'b1;
        end
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_latency"}, cyc - cur_acc, e.latency);
                checkOutput({e.name, "_wen_cycles"}, wen_mask, e.wen_mask);
`ifdef DMEM_MOVER_CHECKSUM_EN
                checkOutput({e.name, "_checksum"}, {24'd0, checksum}, {24'd0, e.csum});
`else
                checkOutput({e.name, "_checksum"}, {24'd0, checksum}, 32'd0);
`endif
                for (int i = 0; i < e.n_mem; i++) begin
                    checkOutput($sformatf("%s_mem%0h", e.name, e.addr[i]),
                                {24'd0, mem[e.addr[i]]}, {24'd0, e.data[i]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   idle_wen;

        reset      = 1'b1;
        mem_clear  = 1'b1;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        waitCycles(2);
        reset     = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        $display("[TB] reset and idle");
        checkOutput("rst_busy",     {31'd0, busy},    32'd0);
        checkOutput("rst_done",     {31'd0, done},    32'd0);
        checkOutput("rst_wen",      {31'd0, mem_wen}, 32'd0);
        checkOutput("rst_address",  {24'd0, mem_address}, 32'd0);
        checkOutput("rst_wdata",    {24'd0, mem_write_data}, 32'd0);
        checkOutput("rst_checksum", {24'd0, checksum}, 32'd0);
        idle_wen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_wen) idle_wen++;
        end
        checkOutput("idle_no_writes", idle_wen, 0);

        preload(8'h10, 8'd11);
        preload(8'h11, 8'd22);
        preload(8'h12, 8'd33);
        preload(8'h13, 8'd44);
        preload(8'h14, 8'd55);
        preload(8'h20, 8'd1);
        preload(8'h21, 8'd2);

        $display("[TB] copy of 4 bytes");
        e.name = "copy4"; e.latency = 9; e.wen_mask = 32'h154; e.csum = 8'h6E; e.n_mem = 4;
        e.addr = '0; e.data = '0;
        e.addr[0] = 8'h40; e.data[0] = 8'd11;
        e.addr[1] = 8'h41; e.data[1] = 8'd22;
        e.addr[2] = 8'h42; e.data[2] = 8'd33;
        e.addr[3] = 8'h43; e.data[3] = 8'd44;
        sb.push_back(e);
        applyStimulus(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
        waitCycles(12);

        $display("[TB] fill with wrap");
        e.name = "fillwrap"; e.latency = 4; e.wen_mask = 32'hE; e.csum = 8'hEF; e.n_mem = 3;
        e.addr = '0; e.data = '0;
        e.addr[0] = 8'hFE; e.data[0] = 8'hA5;
        e.addr[1] = 8'hFF; e.data[1] = 8'hA5;
        e.addr[2] = 8'h00; e.data[2] = 8'hA5;
        sb.push_back(e);
        applyStimulus(1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5);
        waitCycles(6);
        checkOutput("fillwrap_mem01_untouched", {24'd0, mem[8'h01]}, 32'd0);

        $display("[TB] zero length");
        e.name = "zerolen"; e.latency = 1; e.wen_mask = 32'h0; e.csum = 8'h00; e.n_mem = 0;
        e.addr = '0; e.data = '0;
        sb.push_back(e);
        applyStimulus(1'b0, 8'h10, 8'h90, 8'd0, 8'h00);
        waitCycles(4);

        $display("[TB] copy of 5 bytes with a start pulse while busy");
        e.name = "copy5"; e.latency = 11; e.wen_mask = 32'h554; e.csum = 8'hA5; e.n_mem = 5;
        e.addr = '0; e.data = '0;
        e.addr[0] = 8'h50; e.data[0] = 8'd11;
        e.addr[1] = 8'h51; e.data[1] = 8'd22;
        e.addr[2] = 8'h52; e.data[2] = 8'd33;
        e.addr[3] = 8'h53; e.data[3] = 8'd44;
        e.addr[4] = 8'h54; e.data[4] = 8'd55;
        sb.push_back(e);
        applyStimulus(1'b0, 8'h10, 8'h50, 8'd5, 8'h00);
        waitCycles(2);
        mode       = 1'b1;
        dst_addr   = 8'h70;
        length     = 8'd2;
        fill_value = 8'hFF;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        waitCycles(12);
        checkOutput("busy_start_ignored_70", {24'd0, mem[8'h70]}, 32'd0);
        checkOutput("busy_start_ignored_71", {24'd0, mem[8'h71]}, 32'd0);

        $display("[TB] overlapping forward copy");
        e.name = "overlap"; e.latency = 7; e.wen_mask = 32'h54; e.csum = 8'h03; e.n_mem = 3;
        e.addr = '0; e.data = '0;
        e.addr[0] = 8'h21; e.data[0] = 8'd1;
        e.addr[1] = 8'h22; e.data[1] = 8'd1;
        e.addr[2] = 8'h23; e.data[2] = 8'd1;
        sb.push_back(e);
        applyStimulus(1'b0, 8'h20, 8'h21, 8'd3, 8'h00);
        waitCycles(10);

        $display("[TB] reset in the middle of a copy");
        applyStimulus(1'b0, 8'h10, 8'h60, 8'd4, 8'h00);
        waitCycles(2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy",     {31'd0, busy},    32'd0);
        checkOutput("midrst_done",     {31'd0, done},    32'd0);
        checkOutput("midrst_wen",      {31'd0, mem_wen}, 32'd0);
        checkOutput("midrst_address",  {24'd0, mem_address}, 32'd0);
        checkOutput("midrst_checksum", {24'd0, checksum}, 32'd0);
        reset = 1'b0;
        waitCycles(4);
        checkOutput("midrst_mem60", {24'd0, mem[8'h60]}, 32'd11);
        checkOutput("midrst_mem61", {24'd0, mem[8'h61]}, 32'd0);

        $display("[TB] fill after aborted copy");
        e.name = "fillafter"; e.latency = 3; e.wen_mask = 32'h6; e.csum = 8'h78; e.n_mem = 2;
        e.addr = '0; e.data = '0;
        e.addr[0] = 8'h80; e.data[0] = 8'h3C;
        e.addr[1] = 8'h81; e.data[1] = 8'h3C;
        sb.push_back(e);
        applyStimulus(1'b1, 8'h00, 8'h80, 8'd2, 8'h3C);
        waitCycles(6);
        checkOutput("fillafter_mem82", {24'd0, mem[8'h82]}, 32'd0);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
- Sequential initiator that drives the DataMemory port (`wen`, `address`, `writeData`) and consumes its combinational read data.
- Performs block COPY (memory to memory) or FILL (constant to memory) of up to 255 bytes, one command at a time.
- Sits beside the core as the master side of the data-memory interface, with a start/busy/done handshake to the controller.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W; all pointer arithmetic is modulo 2**ADDR_W.
- DATA_W, 8, data width; matches the memory word.

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  command request, sampled only in IDLE
- mode  in  1  0 = COPY, 1 = FILL
- src_addr  in  ADDR_W  COPY source base
- dst_addr  in  ADDR_W  destination base
- length  in  8  byte count, 0..255
- fill_value  in  DATA_W  FILL constant
- busy  out  1  high in READ and WRITE states
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_W  sum of written bytes (see Optional Feature)
- mem_wen  out  1  to DataMemory `wen`
- mem_address  out  ADDR_W  to DataMemory `address`
- mem_write_data  out  DATA_W  to DataMemory `writeData`
- mem_read_data  in  DATA_W  from DataMemory `dataMemoryOut`; combinational w.r.t. mem_address

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset values, applied on the posedge where reset is high:
  - state = IDLE
  - busy = 0, done = 0, mem_wen = 0
  - mem_address = 0, mem_write_data = 0, checksum = 0
  - internal pointers, count and data buffer = 0
- Outputs are registered-state decodes: busy, done, mem_wen and mem_address are functions of state and registers only, with no combinational path from start.
- IDLE:
  - mem_wen = 0; mem_address = 0.
  - On an edge with start = 1, latch src_addr, dst_addr, length, mode and fill_value.
  - If length = 0, go to DONE.
  - Otherwise go to READ for COPY, or to WRITE for FILL.
- READ (COPY only):
  - mem_address = src_ptr; mem_wen = 0.
  - At posedge, capture mem_read_data into buf and go to WRITE.
- WRITE:
  - mem_address = dst_ptr; mem_wen = 1.
  - mem_write_data = buf for COPY, or the latched fill_value for FILL.
  - At posedge: src_ptr++, dst_ptr++, remaining--.
  - If remaining was 1, go to DONE.
  - Otherwise go to READ for COPY, or stay in WRITE for FILL.
- DONE: done = 1 for exactly one cycle, busy = 0, then go to IDLE unconditionally.
- Latency, counted from the start-accept edge to the first cycle with done high:
  - COPY: 2N cycles of memory activity, then done in cycle 2N+1.
  - FILL: N cycles, then done in cycle N+1.
  - length = 0: done in cycle 1, with no memory write.
- Back-to-back commands: a new start is accepted no earlier than the IDLE cycle following DONE.
- start while busy or in DONE: ignored, not queued. Changes to the input operands after acceptance have no effect.
- Wrap-around: pointers increment modulo 2**ADDR_W, so 0xFF + 1 = 0x00. No error is flagged.
- Overlap: copy is strictly forward and byte-by-byte.
  - If dst = src + k with 0 < k < N, source bytes are overwritten before they are read. This yields a repeating pattern of period k and is the defined behaviour.
  - dst = src rewrites each byte with itself.
- Reset mid-operation: abort on that edge, return to IDLE with all outputs at their reset values. Bytes already written stay written. No done pulse.

Optional Feature:
- Macro: DMEM_MOVER_CHECKSUM_EN.
- Defined:
  - checksum is cleared to 0 on start acceptance.
  - On each WRITE posedge, checksum += mem_write_data, modulo 2**DATA_W.
  - The value holds stable from DONE until the next accepted start.
  - For length = 0, checksum = 0.
- Undefined: checksum is tied to 0 and the accumulator logic is absent. The port remains so the interface is identical either way.

Test Plan:
- Reset then idle: hold reset 2 cycles, then release -> busy = 0, done = 0, mem_wen = 0, mem_address = 0, checksum = 0; no writes for 10 cycles.
- COPY: preload mem[0x10..0x13] = 11, 22, 33, 44; start with mode = 0, src = 0x10, dst = 0x40, length = 4.
  - mem[0x40..0x43] = 11, 22, 33, 44.
  - done pulses exactly once, in cycle 9 after accept.
  - mem_wen high in cycles 2, 4, 6, 8 only.
  - checksum = 0x6E when the macro is defined.
- FILL with wrap: start with mode = 1, dst = 0xFE, length = 3, fill_value = 0xA5.
  - mem[0xFE], mem[0xFF] and mem[0x00] = 0xA5; mem[0x01] unchanged.
  - done in cycle 4; checksum = 0xEF when the macro is defined.
- Zero length, and start while busy:
  - start with length = 0 -> done in cycle 1, no mem_wen.
  - During a COPY of length 5, pulse start with different operands -> ignored; only the original 5 bytes are copied and one done is issued.
- Overlapping copy: mem[0x20..0x21] = 1, 2; COPY src = 0x20, dst = 0x21, length = 3 -> mem[0x21..0x23] = 1, 1, 1.
- Reset mid-op: assert reset in cycle 3 of a length-4 COPY.
  - Next cycle: IDLE, mem_wen = 0, no done.
  - Only dst byte 0 is written.
  - A following FILL completes normally.
